// File: rtl/xor_op.sv
// XOR/XNOR operation unit for the 24-bit datapath: registered result plus zero/parity flags.
// Bit 0 is the MSB throughout; the word is split into lanes that each produce a partial flag.

module xor_lane #(
  parameter int LANE_W = 8
) (
  input  logic [0:LANE_W-1] a,
  input  logic [0:LANE_W-1] b,
  input  logic              neg,
  output logic [0:LANE_W-1] r,
  output logic              lane_zero,
  output logic              lane_par
);
  always_comb begin
    r         = neg ? ~(a ^ b) : (a ^ b);
    lane_zero = ~|r;
    lane_par  = ^r;
  end
endmodule

module xor_op #(
  parameter int WIDTH  = 24,
  parameter int LANE_W = 8   // WIDTH must be a multiple of LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic             neg,
  output logic [0:WIDTH-1] y,
  output logic             out_valid,
  output logic             zero,
  output logic             parity
);
  localparam int NUM_LANES = WIDTH / LANE_W;
  localparam int STAGES    = 1;

  typedef struct packed {
    logic [0:WIDTH-1] y;
    logic             zero;
    logic             parity;
  } rsp_t;

  logic [0:WIDTH-1]     res;
  logic [NUM_LANES-1:0] lane_zero;
  logic [NUM_LANES-1:0] lane_par;
  logic [STAGES:0]      vld_pipe;
  rsp_t                 rsp_d, rsp_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    xor_lane #(.LANE_W(LANE_W)) u_lane (
      .a         (a[l*LANE_W +: LANE_W]),
      .b         (b[l*LANE_W +: LANE_W]),
      .neg       (neg),
      .r         (res[l*LANE_W +: LANE_W]),
      .lane_zero (lane_zero[l]),
      .lane_par  (lane_par[l])
    );
  end

  always_comb begin
    rsp_d.y      = res;
    rsp_d.zero   = &lane_zero;
    rsp_d.parity = ^lane_par;
  end

  assign vld_pipe[0] = in_valid;

  // Result flops only load on a valid request so y/flags hold across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      rsp_q              <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (in_valid) rsp_q <= rsp_d;
    end
  end

  assign y         = rsp_q.y;
  assign zero      = rsp_q.zero;
  assign parity    = rsp_q.parity;
  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_xor_op.sv
// Self-checking bench for xor_op: directed vector table, hand sequences, randomized model check.

module tb_xor_op;
  localparam int WIDTH = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [0:WIDTH-1] a = '0;
  logic [0:WIDTH-1] b = '0;
  logic             neg = 1'b0;
  logic [0:WIDTH-1] y;
  logic             out_valid, zero, parity;

  xor_op #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .neg(neg),
    .y(y), .out_valid(out_valid), .zero(zero), .parity(parity)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural reference: what the outputs should show after each edge.
  logic [0:WIDTH-1] m_y;
  logic             m_vld, m_zero, m_par;

  typedef struct {
    logic [0:WIDTH-1] a, b;
    logic             neg;
    logic [0:WIDTH-1] ey;
    logic             ez, ep;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_vld});
    chk({tag, ".y"},         {8'd0, y},          {8'd0, m_y});
    chk({tag, ".zero"},      {31'd0, zero},      {31'd0, m_zero});
    chk({tag, ".parity"},    {31'd0, parity},    {31'd0, m_par});
  endtask

  // Drive one request (or idle) across one edge, update the model, then check.
  task automatic apply(input logic v, input logic [0:WIDTH-1] ta, input logic [0:WIDTH-1] tb,
                       input logic tn, input string tag);
    logic [0:WIDTH-1] r;
    in_valid = v; a = ta; b = tb; neg = tn;
    @(posedge clk);
    if (v) begin
      r = ta ^ tb;
      if (tn) r = ~r;
      m_y    = r;
      m_zero = (r == 0);
      m_par  = ($countones(r) % 2) == 1;
    end
    m_vld = v;
    #1;
    chk_model(tag);
  endtask

  task automatic model_reset();
    m_y = '0; m_vld = 1'b0; m_zero = 1'b0; m_par = 1'b0;
  endtask

  initial begin
    vecs[0] = '{24'hF010FF, 24'h000000, 1'b0, 24'hF010FF, 1'b0, 1'b1};
    vecs[1] = '{24'hF010FF, 24'hFFFFFF, 1'b0, 24'h0FEF00, 1'b0, 1'b1};
    vecs[2] = '{24'hF010FF, 24'hFFF000, 1'b0, 24'h0FE0FF, 1'b0, 1'b1};
    vecs[3] = '{24'h123456, 24'h123456, 1'b0, 24'h000000, 1'b1, 1'b0};
    vecs[4] = '{24'h123456, 24'h123456, 1'b1, 24'hFFFFFF, 1'b0, 1'b0};

    model_reset();
    // Reset state, both during reset and after release with no request.
    #3;
    chk_model("reset_async");
    @(negedge clk); rst = 1'b0;
    apply(1'b0, '0, '0, 1'b0, "reset_release");

    // Directed table: one request then compare against the table constants.
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, vecs[i].a, vecs[i].b, vecs[i].neg, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tab_y", i),  {8'd0, y},          {8'd0, vecs[i].ey});
      chk($sformatf("vec%0d.tab_z", i),  {31'd0, zero},      {31'd0, vecs[i].ez});
      chk($sformatf("vec%0d.tab_p", i),  {31'd0, parity},    {31'd0, vecs[i].ep});
      chk($sformatf("vec%0d.tab_v", i),  {31'd0, out_valid}, 32'd1);
    end

    // Back-to-back requests, then idle: result holds, valid drops.
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, vecs[i].a, vecs[i].b, vecs[i].neg, $sformatf("b2b%0d", i));
      chk($sformatf("b2b%0d.tab_y", i), {8'd0, y}, {8'd0, vecs[i].ey});
    end
    apply(1'b0, 24'hABCDEF, 24'h135790, 1'b1, "idle0");
    chk("idle0.hold_y", {8'd0, y}, 32'h000FE0FF);
    chk("idle0.vld",    {31'd0, out_valid}, 32'd0);
    apply(1'b0, '0, '0, 1'b0, "idle1");

    // Reset mid-stream: outputs clear without waiting for an edge.
    apply(1'b1, 24'hF010FF, 24'h000000, 1'b0, "pre_rst");
    in_valid = 1'b1; a = 24'h00FF00; b = 24'h0000FF;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_model("mid_rst");
    chk("mid_rst.y0", {8'd0, y}, 32'd0);
    @(negedge clk); rst = 1'b0;
    apply(1'b0, 24'h111111, 24'h222222, 1'b0, "post_rst_idle");
    apply(1'b1, 24'h00FF00, 24'h0000FF, 1'b0, "post_rst_req");

    // Randomized traffic against the model; a=b sometimes to exercise zero.
    for (int i = 0; i < 400; i++) begin
      logic             v, n;
      logic [0:WIDTH-1] ra, rb;
      v  = ($urandom_range(0, 3) != 0);
      n  = $urandom_range(0, 1) == 1;
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
      if ($urandom_range(0, 15) == 0) rb = ~ra;
      apply(v, ra, rb, n, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
